vec_collect: RTL and testbench
==============================

# vec_collect

Receive-side companion to the popcount stage. Consumes its sub-vector stream (BUS_WIDTH-wide words, SUB_VECTOR_NO words per vector) together with the per-vector popcount. Reassembles each full VECTOR_WIDTH-bit vector, attaches its count, and presents vector and count to the downstream comparator over a valid/ready interface. A two-entry output buffer lets assembly of the next vector continue while downstream stalls.

## Interface
- VECTOR_WIDTH, 920, bits per full vector
- BUS_WIDTH, 128, bits per sub-vector word
- SUB_VECTOR_NO, ceil(VECTOR_WIDTH/BUS_WIDTH), words per vector
- CNT_WIDTH, $clog2(VECTOR_WIDTH), popcount width
- clk  in  1  clock
- rstn  in  1  reset, synchronous, active-low
- up_SubVector  in  BUS_WIDTH  sub-vector word
- up_Valid  in  1  word valid
- up_Cnt  in  CNT_WIDTH  popcount of the current vector; meaningful when up_CntNew=1
- up_CntNew  in  1  marks the final word of a vector
- up_Last  in  1  final word of the final vector in the stream
- up_Ready  out  1  block accepts a word
- dn_Vector  out  VECTOR_WIDTH  assembled vector
- dn_Cnt  out  CNT_WIDTH  popcount belonging to dn_Vector
- dn_Last  out  1  dn_Vector is the last vector of the stream
- dn_Valid  out  1  output entry valid
- dn_Ready  in  1  downstream accepts
- o_FrameErr  out  1  sticky framing error

## Operation
- Upstream beat occurs when up_Valid && up_Ready. Downstream beat occurs when dn_Valid && dn_Ready.
- Word index counter r_Idx runs 0..SUB_VECTOR_NO-1. It increments on each upstream beat and wraps to 0 after the final index. r_Idx alone governs framing.
- Word k is written to assembly bits [k*BUS_WIDTH +: BUS_WIDTH]. On the final word, bits above VECTOR_WIDTH-1 are discarded. At defaults this is word 7, with 24 bits kept and 104 dropped.
- On the beat at r_Idx = SUB_VECTOR_NO-1:
  - up_Cnt is captured.
  - The assembled vector, count and last flag are pushed into the output buffer as one entry.
- Last flag: OR of up_Last over all beats of the vector. It is cleared when the entry is pushed.
- o_FrameErr is set, and stays set until reset, on any of these:
  - up_CntNew=1 at r_Idx != final index;
  - up_CntNew=0 at the final index;
  - up_Last=1 at a non-final index.
- A framing error changes no data path: the vector is still emitted when r_Idx reaches the final index.
- Output buffer: 2 entries, FIFO order. The head entry drives dn_Vector, dn_Cnt and dn_Last.
- up_Ready = (occupancy < 2). It is registered and has no combinational path from dn_Ready.
  - At occupancy 2 with a downstream pop in progress, up_Ready stays 0 that cycle and rises the next cycle.
- A push and a pop in the same cycle leave occupancy unchanged.

## Timing
- Latency: final word accepted at edge T, then dn_Valid=1 with that vector after edge T (visible cycle T+1).
- When the buffer was empty, the first vector appears with exactly 1-cycle latency.
- Throughput: 1 word/cycle sustained while dn_Ready=1. up_Ready never drops in that case.
- Output hold: while dn_Valid=1 and dn_Ready=0, dn_Vector, dn_Cnt and dn_Last are stable.
- Reset, while rstn=0 and on the first cycle after:
  - r_Idx=0, occupancy=0, assembly register cleared, last flag 0;
  - dn_Valid=0, dn_Vector=0, dn_Cnt=0, dn_Last=0, o_FrameErr=0;
  - up_Ready=0 while rstn=0, and 1 on the first cycle after release.
- Reset mid-vector drops the partial vector and any buffered entries.
- Wrap: the beat after the final index writes word 0 of the next vector in the same cycle the previous entry is pushed. Nothing is lost.

## Structure
- Shared package fp_accel_pkg holds:
  - function f_sub_vector_no(VECTOR_WIDTH, BUS_WIDTH), giving the ceil division;
  - the CNT_WIDTH derivation;
  - shared by the popcount stage and this block.
- Sub-module vec_fifo2: 2-entry register FIFO of width VECTOR_WIDTH+CNT_WIDTH+1. It exposes push, pop, head, occupancy and a registered not-full flag.
- Top level holds the index counter, assembly register, last-flag accumulation and error detection.

## Test plan
- Single all-ones vector: 8 words of 128'hFF..F, up_CntNew=1 with up_Cnt=920 on word 7, dn_Ready=1 -> one cycle later dn_Valid=1, dn_Vector all 920 ones, dn_Cnt=920, dn_Last=0, o_FrameErr=0.
- Back-to-back 3 vectors, word k of vector v = {16{v[3:0],k[3:0]}}, dn_Ready=1 -> up_Ready constantly 1; 3 outputs in order; each bit slice matches; word 7 truncated to its low 24 bits.
- Backpressure: dn_Ready=0 while 3 vectors are offered -> up_Ready falls the cycle after vector 2's word 7 and vector 3 word 0 is held. Raise dn_Ready -> vector 1 pops, up_Ready=1 the next cycle, all 3 vectors are delivered intact.
- Framing error: up_CntNew=1 on word 3 -> o_FrameErr=1 from the next cycle and stays 1; the vector is still emitted after word 7 with up_Cnt captured at word 7.
- Reset mid-vector: apply rstn=0 after word 4 -> no output, all outputs 0. The next full vector after release is assembled from word 0 correctly.
- Stream end: up_Last=1 on word 7 of vector 2 of 2 -> dn_Last=0 with vector 1 and dn_Last=1 with vector 2.

Source files
------------

// File: rtl/fp_accel_pkg.sv
// fp_accel_pkg
// Shared sizing helpers for the popcount stage and its receive-side
// companion (vec_collect). Both ends derive the sub-vector word count and
// the popcount width the same way, so the two blocks always agree on framing.
package fp_accel_pkg;

  localparam int VECTOR_WIDTH_DEF = 920;
  localparam int BUS_WIDTH_DEF    = 128;

  // Number of bus words needed to carry one full vector (ceil division).
  function automatic int f_sub_vector_no(input int vector_width, input int bus_width);
    return (vector_width + bus_width - 1) / bus_width;
  endfunction

  // Width of the per-vector popcount.
  function automatic int f_cnt_width(input int vector_width);
    return $clog2(vector_width);
  endfunction

endpackage

// File: rtl/vec_collect_if.sv
// vec_collect_if
// Groups the upstream sub-vector stream and the downstream vector/count
// handshake of vec_collect.
//   master : stream source / vector sink (drives up_*, dn_Ready)
//   slave  : vec_collect itself (drives up_Ready, dn_*)
interface vec_collect_if
  import fp_accel_pkg::*;
#(
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF
);
  localparam int CNT_WIDTH = f_cnt_width(VECTOR_WIDTH);

  logic [BUS_WIDTH-1:0]    up_SubVector;
  logic                    up_Valid;
  logic [CNT_WIDTH-1:0]    up_Cnt;
  logic                    up_CntNew;
  logic                    up_Last;
  logic                    up_Ready;
  logic [VECTOR_WIDTH-1:0] dn_Vector;
  logic [CNT_WIDTH-1:0]    dn_Cnt;
  logic                    dn_Last;
  logic                    dn_Valid;
  logic                    dn_Ready;

  modport master (
    output up_SubVector, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    input  up_Ready, dn_Vector, dn_Cnt, dn_Last, dn_Valid
  );

  modport slave (
    input  up_SubVector, up_Valid, up_Cnt, up_CntNew, up_Last, dn_Ready,
    output up_Ready, dn_Vector, dn_Cnt, dn_Last, dn_Valid
  );

endinterface

// File: rtl/vec_fifo2.sv
// vec_fifo2
// Two-entry register FIFO. Entry 0 is always the head.
// Ports:
//   clk, rstn   clock, synchronous active-low reset
//   push, din   write one entry (ignored when full)
//   pop         drop the head entry (ignored when empty)
//   head        current head entry
//   occ         occupancy 0..2
//   not_full    registered occ < 2; depends only on state, never on pop
module vec_fifo2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       occ,
  output logic             not_full
);

  logic [WIDTH-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]       occ_q, occ_d;
  logic             not_full_q, not_full_d;
  logic             push_ok, pop_ok;

  assign push_ok = push & not_full_q;
  assign pop_ok  = pop & (occ_q != 2'd0);

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    occ_d  = occ_q;
    unique case ({push_ok, pop_ok})
      2'b10: begin
        if (occ_q == 2'd0) ent0_d = din;
        else               ent1_d = din;
        occ_d = occ_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        occ_d  = occ_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged; the new entry lands behind whatever remains.
        if (occ_q == 2'd2) begin
          ent0_d = ent1_q;
          ent1_d = din;
        end else begin
          ent0_d = din;
        end
      end
      default: ;
    endcase
    // Computed from the next occupancy so a pop at occ=2 frees the slot
    // one cycle later rather than combinationally.
    not_full_d = (occ_d != 2'd2);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ent0_q     <= '0;
      ent1_q     <= '0;
      occ_q      <= 2'd0;
      not_full_q <= 1'b0;
    end else begin
      ent0_q     <= ent0_d;
      ent1_q     <= ent1_d;
      occ_q      <= occ_d;
      not_full_q <= not_full_d;
    end
  end

  assign head     = ent0_q;
  assign occ      = occ_q;
  assign not_full = not_full_q;

endmodule

// File: rtl/vec_collect.sv
// vec_collect
// Reassembles VECTOR_WIDTH-bit vectors from a stream of BUS_WIDTH-bit words,
// attaches the popcount delivered with the final word, and hands vector,
// count and last flag downstream through a two-entry buffer.
// Ports:
//   clk, rstn    clock, synchronous active-low reset
//   bus (slave)  up_* sub-vector stream in, dn_* assembled vector out
//   o_FrameErr   sticky framing error, cleared only by reset
module vec_collect
  import fp_accel_pkg::*;
#(
  parameter int VECTOR_WIDTH = VECTOR_WIDTH_DEF,
  parameter int BUS_WIDTH    = BUS_WIDTH_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  vec_collect_if.slave  bus,
  output logic          o_FrameErr
);

  localparam int SUB_VECTOR_NO = f_sub_vector_no(VECTOR_WIDTH, BUS_WIDTH);
  localparam int CNT_WIDTH     = f_cnt_width(VECTOR_WIDTH);
  localparam int IDX_W         = (SUB_VECTOR_NO > 1) ? $clog2(SUB_VECTOR_NO) : 1;
  localparam int PAD_W         = SUB_VECTOR_NO * BUS_WIDTH;
  localparam int ENT_W         = VECTOR_WIDTH + CNT_WIDTH + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SUB_VECTOR_NO - 1);

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [VECTOR_WIDTH-1:0] asm_q, asm_d;
  logic                    last_q, last_d;
  logic                    err_q, err_d;

  logic [PAD_W-1:0] asm_pad;
  logic             beat, is_final, push, pop;
  logic [ENT_W-1:0] ent_in, head;
  logic [1:0]       occ;
  logic             not_full;

  assign beat     = bus.up_Valid & not_full;
  assign is_final = (idx_q == LAST_IDX);
  assign pop      = bus.dn_Valid & bus.dn_Ready;

  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    last_d  = last_q;
    err_d   = err_q;
    push    = 1'b0;
    ent_in  = '0;
    // Word slots are laid out on a BUS_WIDTH grid; the padded view lets the
    // final word be written whole, with bits past VECTOR_WIDTH dropped.
    asm_pad = PAD_W'(asm_q);
    if (beat) begin
      asm_pad[int'(idx_q) * BUS_WIDTH +: BUS_WIDTH] = bus.up_SubVector;
      asm_d  = asm_pad[VECTOR_WIDTH-1:0];
      last_d = last_q | bus.up_Last;
      // Framing is judged by the index alone; data still flows on error.
      if ((bus.up_CntNew != is_final) || (bus.up_Last && !is_final)) err_d = 1'b1;
      if (is_final) begin
        idx_d  = '0;
        push   = 1'b1;
        ent_in = {asm_d, bus.up_Cnt, last_d};
        last_d = 1'b0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  if (PAD_W > VECTOR_WIDTH) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^asm_pad[PAD_W-1:VECTOR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      idx_q  <= '0;
      asm_q  <= '0;
      last_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      asm_q  <= asm_d;
      last_q <= last_d;
      err_q  <= err_d;
    end
  end

  vec_fifo2 #(.WIDTH(ENT_W)) u_fifo (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .pop      (pop),
    .din      (ent_in),
    .head     (head),
    .occ      (occ),
    .not_full (not_full)
  );

  assign {bus.dn_Vector, bus.dn_Cnt, bus.dn_Last} = head;
  assign bus.dn_Valid = (occ != 2'd0);
  assign bus.up_Ready = not_full;
  assign o_FrameErr   = err_q;

endmodule

// File: tb/tb_vec_collect.sv
module tb_vec_collect;
  import fp_accel_pkg::*;

  localparam int VW = 920;
  localparam int BW = 128;
  localparam int NW = f_sub_vector_no(VW, BW);
  localparam int CW = f_cnt_width(VW);

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic o_FrameErr;

  always #5 clk = ~clk;

  vec_collect_if #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW)) bus ();

  vec_collect #(.VECTOR_WIDTH(VW), .BUS_WIDTH(BW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus),
    .o_FrameErr (o_FrameErr)
  );

  typedef struct {
    logic [VW-1:0] vec;
    logic [CW-1:0] cnt;
    logic          last;
  } exp_t;

  typedef struct {
    logic [3:0]    tag;
    bit            ones;
    logic [CW-1:0] cnt;
    bit            last;
    bit            gap;
    logic [VW-1:0] exp_vec;
    logic [CW-1:0] exp_cnt;
    bit            exp_last;
  } rec_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [1023:0] got, input logic [1023:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h (ones %0d) want %h (ones %0d)", name,
               got[127:0], $countones(got), want[127:0], $countones(want));
    end
  endtask

  function automatic logic [BW-1:0] pat(input logic [3:0] v, input logic [3:0] k);
    return {16{v, k}};
  endfunction

  function automatic logic [VW-1:0] pat_vec(input logic [3:0] v);
    logic [NW*BW-1:0] t;
    t = '0;
    for (int k = 0; k < NW; k++) t[k*BW +: BW] = pat(v, 4'(k));
    return t[VW-1:0];
  endfunction

  task automatic send_word(input logic [BW-1:0] w, input logic [CW-1:0] c,
                           input logic cn, input logic lst, output bit stalled);
    int guard;
    @(posedge clk); #2;
    bus.up_SubVector = w;
    bus.up_Cnt       = c;
    bus.up_CntNew    = cn;
    bus.up_Last      = lst;
    bus.up_Valid     = 1'b1;
    stalled = 1'b0;
    guard   = 0;
    while (!bus.up_Ready && guard < 100) begin
      stalled = 1'b1;
      @(posedge clk); #2;
      guard++;
    end
    if (guard >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: got up_Ready=0 for 100 cycles want 1");
    end
  endtask

  task automatic send_vec(input logic [3:0] tag, input bit ones, input logic [CW-1:0] c,
                          input bit lst, output bit any_stall);
    bit st;
    any_stall = 1'b0;
    for (int k = 0; k < NW; k++) begin
      send_word(ones ? {BW{1'b1}} : pat(tag, 4'(k)), c, k == NW-1, lst && (k == NW-1), st);
      any_stall |= st;
    end
  endtask

  task automatic idle();
    @(posedge clk); #2;
    bus.up_Valid  = 1'b0;
    bus.up_CntNew = 1'b0;
    bus.up_Last   = 1'b0;
  endtask

  // Scoreboard and output-hold monitor, sampled mid-cycle.
  bit            hold_prev = 1'b0;
  logic [VW-1:0] hold_vec;
  logic [CW-1:0] hold_cnt;
  logic          hold_last;
  exp_t          mon_e;

  always @(negedge clk) begin
    if (hold_prev && bus.dn_Valid) begin
      chk("hold_vec", bus.dn_Vector, hold_vec);
      chk("hold_cnt", bus.dn_Cnt, hold_cnt);
      chk("hold_last", bus.dn_Last, hold_last);
    end
    hold_prev = bus.dn_Valid && !bus.dn_Ready;
    hold_vec  = bus.dn_Vector;
    hold_cnt  = bus.dn_Cnt;
    hold_last = bus.dn_Last;
    if (bus.dn_Valid && bus.dn_Ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL out_unexpected: got dn_Valid=1 want no output pending");
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_vec", bus.dn_Vector, mon_e.vec);
        chk("out_cnt", bus.dn_Cnt, mon_e.cnt);
        chk("out_last", bus.dn_Last, mon_e.last);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by 200000 want finish");
    $fatal(1);
  end

  initial begin
    rec_t tbl[4];
    bit   st;
    logic [VW-1:0] v5, v6, v7;

    tbl[0] = '{tag: 4'd0, ones: 1'b1, cnt: 10'd920, last: 1'b0, gap: 1'b1,
               exp_vec: {VW{1'b1}}, exp_cnt: 10'd920, exp_last: 1'b0};
    tbl[1] = '{tag: 4'd1, ones: 1'b0, cnt: 10'd101, last: 1'b0, gap: 1'b0,
               exp_vec: pat_vec(4'd1), exp_cnt: 10'd101, exp_last: 1'b0};
    tbl[2] = '{tag: 4'd2, ones: 1'b0, cnt: 10'd202, last: 1'b0, gap: 1'b0,
               exp_vec: pat_vec(4'd2), exp_cnt: 10'd202, exp_last: 1'b0};
    tbl[3] = '{tag: 4'd3, ones: 1'b0, cnt: 10'd303, last: 1'b1, gap: 1'b1,
               exp_vec: pat_vec(4'd3), exp_cnt: 10'd303, exp_last: 1'b1};

    bus.up_SubVector = '0;
    bus.up_Valid     = 1'b0;
    bus.up_Cnt       = '0;
    bus.up_CntNew    = 1'b0;
    bus.up_Last      = 1'b0;
    bus.dn_Ready     = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    chk("rst_up_ready", bus.up_Ready, 0);
    chk("rst_dn_valid", bus.dn_Valid, 0);
    chk("rst_dn_vector", bus.dn_Vector, 0);
    chk("rst_dn_cnt", bus.dn_Cnt, 0);
    chk("rst_dn_last", bus.dn_Last, 0);
    chk("rst_frame_err", o_FrameErr, 0);
    rstn = 1'b1;
    @(posedge clk); #2;
    chk("rel_up_ready", bus.up_Ready, 1);
    chk("rel_dn_valid", bus.dn_Valid, 0);

    // Table: all-ones vector, then three back-to-back vectors ending the stream
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back('{vec: tbl[i].exp_vec, cnt: tbl[i].exp_cnt, last: tbl[i].exp_last});
      send_vec(tbl[i].tag, tbl[i].ones, tbl[i].cnt, tbl[i].last, st);
      chk("up_ready_const", st, 0);
      if (tbl[i].gap) begin
        idle();
        chk("lat_valid", bus.dn_Valid, 1);
        chk("lat_vec", bus.dn_Vector, tbl[i].exp_vec);
        chk("lat_cnt", bus.dn_Cnt, tbl[i].exp_cnt);
      end
    end
    idle();
    chk("tbl_frame_err", o_FrameErr, 0);

    // Backpressure: two vectors fill the buffer, third is held off
    v5 = pat_vec(4'd5);
    v6 = pat_vec(4'd6);
    v7 = pat_vec(4'd7);
    bus.dn_Ready = 1'b0;
    exp_q.push_back('{vec: v5, cnt: 10'd55, last: 1'b0});
    exp_q.push_back('{vec: v6, cnt: 10'd66, last: 1'b0});
    exp_q.push_back('{vec: v7, cnt: 10'd77, last: 1'b0});
    send_vec(4'd5, 1'b0, 10'd55, 1'b0, st);
    send_vec(4'd6, 1'b0, 10'd66, 1'b0, st);
    chk("bp_no_stall_2", st, 0);
    @(posedge clk); #2;
    bus.up_SubVector = pat(4'd7, 4'd0);
    bus.up_Cnt       = 10'd77;
    bus.up_CntNew    = 1'b0;
    bus.up_Last      = 1'b0;
    bus.up_Valid     = 1'b1;
    chk("bp_ready_low", bus.up_Ready, 0);
    chk("bp_head_v5", bus.dn_Vector, v5);
    repeat (3) begin
      @(posedge clk); #2;
      chk("bp_ready_held", bus.up_Ready, 0);
    end
    bus.dn_Ready = 1'b1;
    chk("bp_ready_pop_cycle", bus.up_Ready, 0);
    @(posedge clk); #2;
    chk("bp_ready_rise", bus.up_Ready, 1);
    chk("bp_head_v6", bus.dn_Vector, v6);
    bus.up_Valid = 1'b0;
    bus.dn_Ready = 1'b0;
    for (int k = 0; k < NW-1; k++) send_word(pat(4'd7, 4'(k)), 10'd77, 1'b0, 1'b0, st);
    // Final word of v7 pushes in the same cycle v6 pops
    @(posedge clk); #2;
    bus.up_SubVector = pat(4'd7, 4'(NW-1));
    bus.up_CntNew    = 1'b1;
    bus.dn_Ready     = 1'b1;
    chk("bp_ready_v7_final", bus.up_Ready, 1);
    idle();
    chk("pp_valid", bus.dn_Valid, 1);
    chk("pp_head_v7", bus.dn_Vector, v7);
    @(posedge clk); #2;
    chk("pp_drained", bus.dn_Valid, 0);

    // Reset mid-vector
    for (int k = 0; k < 5; k++) send_word(pat(4'd8, 4'(k)), 10'd88, 1'b0, 1'b0, st);
    @(posedge clk); #2;
    bus.up_Valid = 1'b0;
    rstn = 1'b0;
    @(posedge clk); #2;
    chk("mid_rst_up_ready", bus.up_Ready, 0);
    chk("mid_rst_dn_valid", bus.dn_Valid, 0);
    chk("mid_rst_dn_vector", bus.dn_Vector, 0);
    chk("mid_rst_dn_cnt", bus.dn_Cnt, 0);
    chk("mid_rst_dn_last", bus.dn_Last, 0);
    rstn = 1'b1;
    @(posedge clk); #2;
    chk("mid_rel_up_ready", bus.up_Ready, 1);
    exp_q.push_back('{vec: pat_vec(4'd9), cnt: 10'd409, last: 1'b0});
    send_vec(4'd9, 1'b0, 10'd409, 1'b0, st);
    idle();
    chk("mid_after_valid", bus.dn_Valid, 1);
    chk("mid_after_vec", bus.dn_Vector, pat_vec(4'd9));
    chk("mid_after_err", o_FrameErr, 0);

    // Framing error: early CntNew on word 3; vector still emitted
    exp_q.push_back('{vec: pat_vec(4'd10), cnt: 10'd123, last: 1'b0});
    for (int k = 0; k < NW; k++) begin
      send_word(pat(4'd10, 4'(k)), (k == 3) ? 10'd11 : 10'd123, (k == 3) || (k == NW-1), 1'b0, st);
      if (k == 3) chk("ferr_before", o_FrameErr, 0);
      if (k == 4) chk("ferr_set", o_FrameErr, 1);
    end
    idle();
    chk("ferr_valid", bus.dn_Valid, 1);
    chk("ferr_cnt", bus.dn_Cnt, 10'd123);

    repeat (5) idle();
    chk("ferr_sticky", o_FrameErr, 1);
    chk("queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
